// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin write-back arbiter for the single register-file
// write port (ALU, load, mul/div), with a registered write stage and a pending-write
// scoreboard for issue/decode stall logic.
// Optional: define WBARB_BYPASS_EN to add a forwarding path from the write stage.
module regfile_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          req0,
  input  logic          req1,
  input  logic          req2,
  input  logic [AW-1:0] wn0,
  input  logic [AW-1:0] wn1,
  input  logic [AW-1:0] wn2,
  input  logic [DW-1:0] d0,
  input  logic [DW-1:0] d1,
  input  logic [DW-1:0] d2,
  output logic          gnt0,
  output logic          gnt1,
  output logic          gnt2,
  output logic          rf_we,
  output logic [AW-1:0] rf_wn,
  output logic [DW-1:0] rf_d,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_wn,
  output logic          iss_ready,
  input  logic [AW-1:0] rna,
  input  logic [AW-1:0] rnb,
  output logic          stall_a,
  output logic          stall_b
`ifdef WBARB_BYPASS_EN
  ,
  output logic          byp_a_hit,
  output logic          byp_b_hit,
  output logic [DW-1:0] byp_d
`endif
);

  localparam int unsigned NREG = 2 ** AW;

  // Pointer holds the index granted most recently; search starts one past it.
  typedef enum logic [1:0] {
    LAST0 = 2'd0,
    LAST1 = 2'd1,
    LAST2 = 2'd2
  } rr_t;

  rr_t             ptr, ptr_nxt;
  logic [2:0]      gnt;
  logic [AW-1:0]   sel_wn;
  logic [DW-1:0]   sel_d;
  logic [NREG-1:0] pending, pending_nxt;
  logic            set_en;

  // Round-robin pointer register
  always_ff @(posedge clk) begin
    if (clr) ptr <= LAST2;
    else     ptr <= ptr_nxt;
  end

  // Grant selection in rotating priority order, next pointer and write-data mux
  always_comb begin
    gnt     = '0;
    ptr_nxt = ptr;
    sel_wn  = '0;
    sel_d   = '0;
    if (!clr) begin
      case (ptr)
        LAST2: begin
          if      (req0) gnt = 3'b001;
          else if (req1) gnt = 3'b010;
          else if (req2) gnt = 3'b100;
        end
        LAST0: begin
          if      (req1) gnt = 3'b010;
          else if (req2) gnt = 3'b100;
          else if (req0) gnt = 3'b001;
        end
        default: begin
          if      (req2) gnt = 3'b100;
          else if (req0) gnt = 3'b001;
          else if (req1) gnt = 3'b010;
        end
      endcase
    end
    if (gnt[0]) begin
      ptr_nxt = LAST0;
      sel_wn  = wn0;
      sel_d   = d0;
    end else if (gnt[1]) begin
      ptr_nxt = LAST1;
      sel_wn  = wn1;
      sel_d   = d1;
    end else if (gnt[2]) begin
      ptr_nxt = LAST2;
      sel_wn  = wn2;
      sel_d   = d2;
    end
  end

  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];
  assign gnt2 = gnt[2];

  // Registered write stage; a grant to r0 is consumed without writing, wn/d hold when idle
  always_ff @(posedge clk) begin
    if (clr) begin
      rf_we <= 1'b0;
      rf_wn <= '0;
      rf_d  <= '0;
    end else if ((gnt != '0) && (sel_wn != '0)) begin
      rf_we <= 1'b1;
      rf_wn <= sel_wn;
      rf_d  <= sel_d;
    end else begin
      rf_we <= 1'b0;
    end
  end

  assign iss_ready = ~clr & ((iss_wn == '0) | ~pending[iss_wn]);
  assign set_en    = iss_valid & iss_ready & (iss_wn != '0);

  // Scoreboard next state: clear on completed write, set on accepted issue; r0 never pending
  always_comb begin
    pending_nxt = pending;
    if (rf_we)  pending_nxt[rf_wn]  = 1'b0;
    if (set_en) pending_nxt[iss_wn] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (clr) pending <= '0;
    else     pending <= pending_nxt;
  end

`ifdef WBARB_BYPASS_EN
  assign byp_a_hit = rf_we & (rf_wn == rna) & (rna != '0);
  assign byp_b_hit = rf_we & (rf_wn == rnb) & (rnb != '0);
  assign byp_d     = rf_d;
  assign stall_a   = pending[rna] & ~byp_a_hit;
  assign stall_b   = pending[rnb] & ~byp_b_hit;
`else
  assign stall_a   = pending[rna];
  assign stall_b   = pending[rnb];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: scoreboard bench; expected register-file writes are queued
// when a grant is predicted and compared when the write stage presents them.
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          clr;
  logic [2:0]    rq;
  logic [AW-1:0] wnv [3];
  logic [DW-1:0] dv  [3];
  logic          gnt0, gnt1, gnt2;
  logic          rf_we;
  logic [AW-1:0] rf_wn;
  logic [DW-1:0] rf_d;
  logic          iss_valid;
  logic [AW-1:0] iss_wn;
  logic          iss_ready;
  logic [AW-1:0] rna, rnb;
  logic          stall_a, stall_b;
`ifdef WBARB_BYPASS_EN
  logic          byp_a_hit, byp_b_hit;
  logic [DW-1:0] byp_d;
`endif

  regfile_wb_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .clr(clr),
    .req0(rq[0]), .req1(rq[1]), .req2(rq[2]),
    .wn0(wnv[0]), .wn1(wnv[1]), .wn2(wnv[2]),
    .d0(dv[0]), .d1(dv[1]), .d2(dv[2]),
    .gnt0(gnt0), .gnt1(gnt1), .gnt2(gnt2),
    .rf_we(rf_we), .rf_wn(rf_wn), .rf_d(rf_d),
    .iss_valid(iss_valid), .iss_wn(iss_wn), .iss_ready(iss_ready),
    .rna(rna), .rnb(rnb), .stall_a(stall_a), .stall_b(stall_b)
`ifdef WBARB_BYPASS_EN
    , .byp_a_hit(byp_a_hit), .byp_b_hit(byp_b_hit), .byp_d(byp_d)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] wn;
    logic [DW-1:0] d;
  } wr_t;

  wr_t        wq [$];
  int         n_chk  = 0;
  int         n_pass = 0;
  logic [1:0] mptr;
  logic [31:0] mpend;
  logic [AW-1:0] m_wn;
  logic [DW-1:0] m_d;
  logic [2:0] lg;
  logic       primed;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [2:0] mgrant(input logic [1:0] p, input logic [2:0] r, input logic c);
    if (c) return 3'b000;
    for (int unsigned k = 1; k <= 3; k++) begin
      int unsigned idx;
      idx = (p + k) % 3;
      if (r[idx]) return 3'b001 << idx;
    end
    return 3'b000;
  endfunction

  // One clock: check at the falling edge, advance the model across the rising edge.
  task automatic cycle();
    logic [2:0]  g;
    logic        rdy, have, ha, hb;
    wr_t         e, nx;
    logic [1:0]  ptr_n;
    logic [31:0] pend_n;
    int unsigned gi;
    @(negedge clk);
    g = mgrant(mptr, rq, clr);
    check("gnt", {29'd0, gnt2, gnt1, gnt0}, {29'd0, g});
    have = 1'b0;
    e = '{we: 1'b0, wn: '0, d: '0};
    if (wq.size() != 0) begin
      e = wq.pop_front();
      have = 1'b1;
      check("rf_we", {31'd0, rf_we}, {31'd0, e.we});
      check("rf_wn", {27'd0, rf_wn}, {27'd0, e.wn});
      check("rf_d", rf_d, e.d);
    end
    rdy = !clr && (iss_wn == 0 || !mpend[iss_wn]);
    check("iss_ready", {31'd0, iss_ready}, {31'd0, rdy});
    ha = have && e.we && e.wn == rna && rna != 0;
    hb = have && e.we && e.wn == rnb && rnb != 0;
    if (primed) begin
`ifdef WBARB_BYPASS_EN
      check("byp_a_hit", {31'd0, byp_a_hit}, {31'd0, ha});
      check("byp_b_hit", {31'd0, byp_b_hit}, {31'd0, hb});
      check("byp_d", byp_d, e.d);
      check("stall_a", {31'd0, stall_a}, {31'd0, mpend[rna] & ~ha});
      check("stall_b", {31'd0, stall_b}, {31'd0, mpend[rnb] & ~hb});
`else
      check("stall_a", {31'd0, stall_a}, {31'd0, mpend[rna]});
      check("stall_b", {31'd0, stall_b}, {31'd0, mpend[rnb]});
`endif
    end
    if (clr) begin
      ptr_n  = 2'd2;
      pend_n = '0;
      m_wn   = '0;
      m_d    = '0;
      nx = '{we: 1'b0, wn: '0, d: '0};
    end else begin
      ptr_n  = mptr;
      pend_n = mpend;
      if (have && e.we) pend_n[e.wn] = 1'b0;
      if (iss_valid && rdy && iss_wn != 0) pend_n[iss_wn] = 1'b1;
      nx = '{we: 1'b0, wn: m_wn, d: m_d};
      if (g != 0) begin
        gi = g[0] ? 0 : (g[1] ? 1 : 2);
        ptr_n = gi[1:0];
        if (wnv[gi] != 0) begin
          m_wn = wnv[gi];
          m_d  = dv[gi];
          nx = '{we: 1'b1, wn: m_wn, d: m_d};
        end
      end
    end
    wq.push_back(nx);
    lg = g;
    @(posedge clk);
    mptr   = ptr_n;
    mpend  = pend_n;
    primed = 1'b1;
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] r);
    iss_valid = 1'b1;
    iss_wn    = r;
    cycle();
    iss_valid = 1'b0;
  endtask

  initial begin
    mptr = 2'd2; mpend = '0; m_wn = '0; m_d = '0; lg = '0; primed = 1'b0;
    clr = 1'b1; rq = 3'b111;
    for (int unsigned i = 0; i < 3; i++) begin
      wnv[i] = AW'(i + 1);
      dv[i]  = 32'hA000_0000 + i;
    end
    iss_valid = 1'b0; iss_wn = '0; rna = '0; rnb = '0;

    // reset with all requests high, then first grant goes to req0
    @(posedge clk); #1;
    cycle(); cycle();
    clr = 1'b0;
    cycle();
    rq = 3'b000;
    cycle();

    // single write through the load port
    rq = 3'b010; wnv[1] = 5'd7; dv[1] = 32'hDEADBEEF;
    cycle();
    rq = 3'b000;
    cycle(); cycle();

    // round robin under full contention; granted requester presents new data
    rq = 3'b111;
    for (int unsigned c = 0; c < 6; c++) begin
      cycle();
      for (int unsigned i = 0; i < 3; i++)
        if (lg[i]) begin
          wnv[i] = AW'(10 + c + i);
          dv[i]  = 32'h1000 * (c + 1) + i;
        end
    end
    rq = 3'b000;
    cycle(); cycle();

    // scoreboard on register 9: reserve, refused re-issue, write, stall release
    issue(5'd9);
    rna = 5'd9;
    issue(5'd9);
    rq = 3'b100; wnv[2] = 5'd9; dv[2] = 32'h0000_0909;
    cycle();
    rq = 3'b000;
    cycle();
    issue(5'd9);
    cycle();

    // register zero never becomes pending and is never written
    rna = '0; rnb = '0;
    issue(5'd0);
    rq = 3'b001; wnv[0] = '0; dv[0] = 32'h5555_5555;
    cycle();
    rq = 3'b000;
    cycle();

    // reset while a write to register 4 is in flight
    issue(5'd4);
    rna = 5'd4;
    rq = 3'b010; wnv[1] = 5'd4; dv[1] = 32'h0000_0444;
    cycle();
    rq = 3'b000; clr = 1'b1;
    cycle();
    clr = 1'b0;
    cycle();

    // write to register 4 again: forwarding window in the write cycle
    issue(5'd4);
    rq = 3'b001; wnv[0] = 5'd4; dv[0] = 32'h4444_0004;
    cycle();
    rq = 3'b000;
    cycle(); cycle();

    // random traffic honouring the hold-until-granted handshake
    for (int unsigned c = 0; c < 300; c++) begin
      for (int unsigned i = 0; i < 3; i++)
        if (!rq[i] || lg[i]) begin
          rq[i]  = ($urandom_range(0, 2) != 0);
          wnv[i] = AW'($urandom_range(0, 7));
          dv[i]  = $urandom;
        end
      iss_valid = $urandom_range(0, 1) != 0;
      iss_wn    = AW'($urandom_range(0, 7));
      rna       = AW'($urandom_range(0, 7));
      rnb       = AW'($urandom_range(0, 7));
      clr       = ($urandom_range(0, 49) == 0);
      cycle();
    end
    clr = 1'b0; rq = 3'b000; iss_valid = 1'b0;
    cycle(); cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
